// File: rtl/serializer_pkg.sv
// serializer_pkg
//   Shared types and helpers for lane_serializer and its holding buffer.
//   - ser_state_e : serializer control state (IDLE, SHIFT)
//   - bit_count   : maps a valid-bit count field to the real bit count N
//   - beat_count  : number of LANES-wide beats needed for N bits
//   - rev_index   : source bit index used for bit-order reversal
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // A count field of zero encodes a full word.
    function automatic int bit_count(input int mod, input int data_w);
        return (mod == 0) ? data_w : mod;
    endfunction

    function automatic int beat_count(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    // Bit i of a reversed word of the given width comes from this source bit.
    function automatic int rev_index(input int i, input int width);
        return width - 1 - i;
    endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// serializer_hold_buf
//   One-entry holding register for a queued {data, mod, msb_first} word,
//   used by lane_serializer only when SERIALIZER_HOLD_EN is defined.
//   Ports:
//     clk_i     in   clock
//     arst_n_i  in   asynchronous active-low reset
//     push_i    in   store data_i (takes priority over pop_i)
//     data_i    in   word to store
//     pop_i     in   entry consumed this cycle
//     val_o     out  entry is occupied
//     data_o    out  stored word
module serializer_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         val_o,
    output logic [W-1:0] data_o
);

    logic         r_full;
    logic [W-1:0] r_data;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (push_i) begin
            r_full <= 1'b1;
            r_data <= data_i;
        end else if (pop_i) begin
            r_full <= 1'b0;
        end
    end

    assign val_o  = r_full;
    assign data_o = r_data;

endmodule

// File: rtl/lane_serializer.sv
// lane_serializer
//   Converts one DATA_W-bit word per valid/ready handshake into LANES-bit
//   beats with per-lane keep, last-beat marker and output backpressure.
//   Build option: define SERIALIZER_HOLD_EN to add a one-entry holding
//   register so consecutive words stream without an idle cycle.
//   Ports:
//     clk_i        in   clock, rising edge
//     arst_n_i     in   asynchronous active-low reset
//     data_i       in   parallel word
//     data_mod_i   in   valid-bit count, 0 = DATA_W
//     msb_first_i  in   1: MSB-first, 0: LSB-first
//     data_val_i   in   word valid
//     data_rdy_o   out  word can be accepted
//     ser_data_o   out  beat payload
//     ser_keep_o   out  per-lane valid
//     ser_last_o   out  final beat of the word
//     ser_val_o    out  beat valid
//     ser_rdy_i    in   downstream accepts beat
//     busy_o       out  a word is being shifted out
//     err_o        out  pulse: a word with an illegal count was dropped
module lane_serializer
    import serializer_pkg::*;
#(
    parameter int   DATA_W   = 16,
    parameter int   LANES    = 1,
    parameter int   MIN_BITS = 3,
    localparam int  MOD_W    = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              msb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic [LANES-1:0]  ser_data_o,
    output logic [LANES-1:0]  ser_keep_o,
    output logic              ser_last_o,
    output logic              ser_val_o,
    input  logic              ser_rdy_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int               CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    ser_state_e        r_state, w_state_next;
    logic [DATA_W-1:0] r_shift;     // bits for beats after the current one
    logic [CNT_W-1:0]  r_rem;       // number of bits held in r_shift
    logic [LANES-1:0]  r_ser_data, r_ser_keep;
    logic              r_ser_last, r_ser_val, r_rdy, r_err;

    logic              w_in_acc, w_in_legal, w_beat_hs, w_last_hs;
    logic              w_core_free, w_load, w_rdy_next;
    logic [DATA_W-1:0] w_src_data, w_src_rev, w_src_mask, w_seq;
    logic [MOD_W-1:0]  w_src_mod;
    logic              w_src_msb;
    logic [CNT_W-1:0]  w_src_n;
    logic [LANES-1:0]  w_keep_load, w_keep_adv;

    assign w_in_acc    = data_val_i && r_rdy;
    assign w_in_legal  = bit_count(int'(data_mod_i), DATA_W) >= MIN_BITS;
    assign w_beat_hs   = r_ser_val && ser_rdy_i;
    assign w_last_hs   = w_beat_hs && r_ser_last;
    // The shifter can take a new word now or as its last beat leaves.
    assign w_core_free = (r_state == IDLE) || w_last_hs;

`ifdef SERIALIZER_HOLD_EN
    localparam int HOLD_W = DATA_W + MOD_W + 1;

    logic              w_hold_val, w_load_hold, w_load_in, w_push;
    logic [HOLD_W-1:0] w_hold_data;

    serializer_hold_buf #(
        .W(HOLD_W)
    ) u_hold (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .push_i  (w_push),
        .data_i  ({data_i, data_mod_i, msb_first_i}),
        .pop_i   (w_load_hold),
        .val_o   (w_hold_val),
        .data_o  (w_hold_data)
    );

    // A held word always goes first; a fresh word bypasses the buffer
    // only when the buffer is empty and the shifter is free.
    assign w_load_hold = w_core_free && w_hold_val;
    assign w_load_in   = w_core_free && !w_hold_val && w_in_acc && w_in_legal;
    assign w_push      = w_in_acc && w_in_legal && !w_load_in;
    assign w_load      = w_load_hold || w_load_in;
    assign {w_src_data, w_src_mod, w_src_msb} = w_hold_val ? w_hold_data
                                              : {data_i, data_mod_i, msb_first_i};
    assign w_rdy_next  = !((w_hold_val && !w_load_hold) || w_push);
`else
    assign w_load      = w_core_free && w_in_acc && w_in_legal;
    assign w_src_data  = data_i;
    assign w_src_mod   = data_mod_i;
    assign w_src_msb   = msb_first_i;
    assign w_rdy_next  = (w_state_next == IDLE);
`endif

    assign w_src_n = CNT_W'(bit_count(int'(w_src_mod), DATA_W));

    // Normalise the word so that serial bit i sits at position i, with
    // bits past N cleared; beats are then just successive low slices.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_norm
            localparam int               SRC = rev_index(gi, DATA_W);
            localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
            assign w_src_rev[gi]  = w_src_data[SRC];
            assign w_src_mask[gi] = (IDX < w_src_n);
        end
        for (gi = 0; gi < LANES; gi++) begin : g_keep
            localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
            assign w_keep_load[gi] = (IDX < w_src_n);
            assign w_keep_adv[gi]  = (IDX < r_rem);
        end
    endgenerate

    assign w_seq = (w_src_msb ? w_src_rev : w_src_data) & w_src_mask;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = SHIFT;
            SHIFT:   if (w_last_hs && !w_load) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_shift    <= '0;
            r_rem      <= '0;
            r_ser_data <= '0;
            r_ser_keep <= '0;
            r_ser_last <= 1'b0;
            r_ser_val  <= 1'b0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rdy <= w_rdy_next;
            r_err <= w_in_acc && !w_in_legal;
            if (w_load) begin
                r_ser_data <= w_seq[LANES-1:0];
                r_ser_keep <= w_keep_load;
                r_ser_last <= (w_src_n <= LANES_C);
                r_ser_val  <= 1'b1;
                r_shift    <= w_seq >> LANES;
                r_rem      <= (w_src_n > LANES_C) ? w_src_n - LANES_C : '0;
            end else if (w_beat_hs) begin
                if (r_ser_last) begin
                    r_ser_data <= '0;
                    r_ser_keep <= '0;
                    r_ser_last <= 1'b0;
                    r_ser_val  <= 1'b0;
                end else begin
                    r_ser_data <= r_shift[LANES-1:0];
                    r_ser_keep <= w_keep_adv;
                    r_ser_last <= (r_rem <= LANES_C);
                    r_shift    <= r_shift >> LANES;
                    r_rem      <= (r_rem > LANES_C) ? r_rem - LANES_C : '0;
                end
            end
        end
    end

    assign data_rdy_o = r_rdy;
    assign ser_data_o = r_ser_data;
    assign ser_keep_o = r_ser_keep;
    assign ser_last_o = r_ser_last;
    assign ser_val_o  = r_ser_val;
    assign busy_o     = (r_state == SHIFT);
    assign err_o      = r_err;

endmodule

// File: doc/lane_serializer.md
# lane_serializer

- Parametrised successor to the team's single-bit parallel-to-serial block.
- Accepts one DATA_W-bit word per valid/ready handshake, with a per-word valid-bit count and bit-order select.
- Emits the word as LANES-bit beats with per-lane keep, last-beat marker and output backpressure.
- Sits between word-oriented datapath logic and narrow serial links; an optional holding register allows back-to-back words with no idle cycle.

## Interface
- DATA_W, 16, input word width; multiple of LANES, ≥ 4
- LANES, 1, output bits per beat; power of two, ≤ DATA_W
- MIN_BITS, 3, smallest legal non-zero bit count; 1 ≤ MIN_BITS ≤ DATA_W
- MOD_W, $clog2(DATA_W), width of data_mod_i (derived, not overridden)

- clk_i  in  1  single clock, all logic on rising edge
- arst_n_i  in  1  asynchronous active-low reset
- data_i  in  DATA_W  parallel word
- data_mod_i  in  MOD_W  valid-bit count; 0 means DATA_W
- msb_first_i  in  1  1: MSB-first, 0: LSB-first; sampled with the word
- data_val_i  in  1  word valid
- data_rdy_o  out  1  block can accept a word this cycle
- ser_data_o  out  LANES  beat payload
- ser_keep_o  out  LANES  per-lane valid
- ser_last_o  out  1  final beat of the word
- ser_val_o  out  1  beat valid
- ser_rdy_i  in  1  downstream accepts beat
- busy_o  out  1  shift register holds an unfinished word
- err_o  out  1  one-cycle pulse: a word with an illegal count was dropped

## Operation
- Accept: data_val_i && data_rdy_o at a rising edge.
- Bit count N = (data_mod_i == 0) ? DATA_W : data_mod_i.
- N < MIN_BITS: the word is accepted but discarded; err_o pulses the next cycle; no beats are produced.
- Bit sequence s_i, for i = 0..N-1:
  - MSB-first: s_i = data[DATA_W-1-i] (top N bits).
  - LSB-first: s_i = data[i] (bottom N bits).
- Beat k, lane j carries s_{k*LANES+j}. Beats per word = ceil(N/LANES).
- Lanes past N in the last beat: data 0, keep 0. All other keep bits are 1.
- States:
  - IDLE: empty.
  - SHIFT: beats pending. IDLE→SHIFT when a legal word is loaded.
  - On a handshake of the last beat: SHIFT→IDLE, or SHIFT→SHIFT if the next word is available (holding register, or an input accepted this cycle).
- ser_val_o stays high and ser_data_o/ser_keep_o/ser_last_o stay stable until ser_rdy_i. The beat counter advances only on ser_val_o && ser_rdy_i.
- busy_o = (state == SHIFT).
- data_mod_i and msb_first_i are captured with the word; later changes have no effect on it.

## Timing
- All outputs are registered.
- Reset (arst_n_i low, immediate): ser_data_o=0, ser_keep_o=0, ser_last_o=0, ser_val_o=0, busy_o=0, err_o=0, data_rdy_o=0.
- data_rdy_o rises on the first clock edge after reset deassertion.
- Reset mid-word discards the word and any held word with no further beats.
- Word accepted at edge E: first beat valid in the cycle after E. With ser_rdy_i held high, the last beat handshake occurs at edge E+beats.
- Next legal word queued: its first beat follows in the next cycle (zero gap).
- Illegal word accepted at edge E: err_o high only in the cycle after E. State unchanged.
- Simultaneous last-beat handshake and input accept: the new word loads directly; no IDLE cycle.

## Configuration
- SERIALIZER_HOLD_EN defined:
  - One-entry holding register.
  - data_rdy_o = holding register empty (or being drained this cycle).
  - A word may be accepted while SHIFT; consecutive words stream gap-free.
- SERIALIZER_HOLD_EN undefined:
  - No holding register; data_rdy_o = !busy_o.
  - A word can only be accepted in IDLE, so at least one idle cycle separates words.
  - All other behaviour is identical.

## Structure
- serializer_pkg:
  - state enum (IDLE, SHIFT).
  - Function bit_count(mod, DATA_W) returning N.
  - Function beat_count(N, LANES).
  - Bit-order reversal function.
- Sub-module serializer_hold_buf:
  - One-entry valid/ready register for {data, mod, msb_first}.
  - Instantiated only under SERIALIZER_HOLD_EN.

## Test plan
- DATA_W=16, LANES=1, 16'hA5F0, mod 0, MSB-first, ser_rdy_i=1 → 16 beats 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0; ser_last_o only on beat 16; busy_o low after.
- LANES=4, 16'h1234, mod 6, LSB-first → 2 beats: beat 1 data 4'h4 keep 4'hF; beat 2 data 4'h3 keep 4'h3, last=1.
- mod 1 and mod 2, 16'hFFFF → no ser_val_o; err_o one-cycle pulse for each word; data_rdy_o stays high.
- LANES=1, ser_rdy_i low for 3 cycles mid-word → ser_data_o stable; no bit lost or duplicated.
- Two back-to-back words, mod 4 each:
  - With SERIALIZER_HOLD_EN: 8 consecutive valid beats.
  - Without: exactly one idle cycle between the words.
- arst_n_i pulsed low at beat 5 of 16 → all outputs 0 immediately; data_rdy_o high one edge after release; no leftover beats.
